vga_console_ctrl: RTL and testbench

VGA_CONSOLE_CTRL -- requirements
Module: vga_console_ctrl

---
 rtl/vga_console_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_ctrl.sv
// Text console controller: takes characters/control codes and drives a VGA
// text-memory bus to print, scroll and clear a COLS x ROWS screen.
module vga_console_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_char_valid,
    output logic        io_char_ready,
    input  logic [7:0]  io_char_data,
    input  logic [7:0]  io_color,
    output logic [6:0]  io_cursor_x,
    output logic [4:0]  io_cursor_y,
    output logic        io_busy,
    output logic [31:0] io_bus_addr,
    output logic [31:0] io_bus_dat2,
    input  logic [31:0] io_bus_dat4,
    output logic        io_bus_sel,
    output logic        io_bus_we,
    input  logic        io_bus_ack
);
    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, FILL} state_t;

    localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
    localparam logic [4:0]  Y_MAX     = 5'(ROWS - 1);
    localparam logic [11:0] C_COLS    = 12'(COLS);
    localparam logic [11:0] LAST      = 12'(ROWS * COLS - 1);
    localparam logic [11:0] SCR_LAST  = 12'((ROWS - 1) * COLS - 1);
    localparam logic [11:0] FILL_BASE = 12'((ROWS - 1) * COLS);

    state_t      r_state, w_state_next;
    logic [6:0]  r_x, w_x_next;
    logic [4:0]  r_y, w_y_next;
    logic [7:0]  r_color, w_color_next;
    logic [11:0] r_idx, w_idx_next;
    logic [15:0] r_rdata, w_rdata_next;
    logic        r_home, w_home_next;
    logic        r_sel, w_sel_next;
    logic        r_we, w_we_next;
    logic        r_first, w_first_next;
    logic [11:0] r_addr, w_addr_next;
    logic [15:0] r_dat, w_dat_next;
    logic [11:0] w_cur_addr;
    logic        w_done;

    assign w_cur_addr = 12'(r_y) * C_COLS + 12'(r_x);
    // The first sel cycle never completes, so a stale ack cannot end a transfer.
    assign w_done     = r_sel && !r_first && io_bus_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_color_next = r_color;
        w_idx_next   = r_idx;
        w_rdata_next = r_rdata;
        w_home_next  = r_home;
        w_sel_next   = r_sel;
        w_we_next    = r_we;
        w_first_next = 1'b0;
        w_addr_next  = r_addr;
        w_dat_next   = r_dat;
        case (r_state)
            IDLE: if (io_char_valid) begin
                w_color_next = io_color;
                case (io_char_data)
                    8'h0D: w_x_next = '0;
                    8'h08: if (r_x != 7'd0) w_x_next = r_x - 7'd1;
                    8'h0A: begin
                        if (r_y < Y_MAX) begin
                            w_x_next = '0;
                            w_y_next = r_y + 5'd1;
                        end else begin
                            // x stays put until the scroll finishes
                            w_state_next = SCR_RD;
                            w_idx_next   = '0;
                            w_home_next  = 1'b0;
                        end
                    end
                    8'h0C: begin
                        w_state_next = FILL;
                        w_idx_next   = '0;
                        w_home_next  = 1'b1;
                        w_sel_next   = 1'b1;
                        w_we_next    = 1'b1;
                        w_first_next = 1'b1;
                        w_addr_next  = '0;
                        w_dat_next   = {io_color, 8'h20};
                    end
                    default: begin
                        w_state_next = PUT;
                        w_sel_next   = 1'b1;
                        w_we_next    = 1'b1;
                        w_first_next = 1'b1;
                        w_addr_next  = w_cur_addr;
                        w_dat_next   = {io_color, io_char_data};
                    end
                endcase
            end
            PUT: if (w_done) begin
                w_sel_next = 1'b0;
                if (r_x < X_MAX) begin
                    w_x_next     = r_x + 7'd1;
                    w_state_next = IDLE;
                end else if (r_y < Y_MAX) begin
                    w_x_next     = '0;
                    w_y_next     = r_y + 5'd1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = SCR_RD;
                    w_idx_next   = '0;
                    w_home_next  = 1'b0;
                end
            end
            SCR_RD: begin
                if (!r_sel) begin
                    w_sel_next   = 1'b1;
                    w_we_next    = 1'b0;
                    w_first_next = 1'b1;
                    w_addr_next  = r_idx + C_COLS;
                    w_dat_next   = '0;
                end else if (w_done) begin
                    w_rdata_next = io_bus_dat4[15:0];
                    w_sel_next   = 1'b0;
                    w_state_next = SCR_WR;
                end
            end
            SCR_WR: begin
                if (!r_sel) begin
                    w_sel_next   = 1'b1;
                    w_we_next    = 1'b1;
                    w_first_next = 1'b1;
                    w_addr_next  = r_idx;
                    w_dat_next   = r_rdata;
                end else if (w_done) begin
                    w_sel_next = 1'b0;
                    if (r_idx == SCR_LAST) begin
                        w_state_next = FILL;
                        w_idx_next   = FILL_BASE;
                    end else begin
                        w_idx_next   = r_idx + 12'd1;
                        w_state_next = SCR_RD;
                    end
                end
            end
            FILL: begin
                if (!r_sel) begin
                    w_sel_next   = 1'b1;
                    w_we_next    = 1'b1;
                    w_first_next = 1'b1;
                    w_addr_next  = r_idx;
                    w_dat_next   = {r_color, 8'h20};
                end else if (w_done) begin
                    w_sel_next = 1'b0;
                    if (r_idx == LAST) begin
                        w_state_next = IDLE;
                        w_x_next     = '0;
                        if (r_home) w_y_next = '0;
                    end else begin
                        w_idx_next = r_idx + 12'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_home  <= 1'b0;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_first <= 1'b0;
            r_addr  <= '0;
            r_dat   <= '0;
        end else begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_color <= w_color_next;
            r_idx   <= w_idx_next;
            r_rdata <= w_rdata_next;
            r_home  <= w_home_next;
            r_sel   <= w_sel_next;
            r_we    <= w_we_next;
            r_first <= w_first_next;
            r_addr  <= w_addr_next;
            r_dat   <= w_dat_next;
        end
    end

    assign io_char_ready = reset && (r_state == IDLE);
    assign io_busy       = (r_state != IDLE);
    assign io_cursor_x   = r_x;
    assign io_cursor_y   = r_y;
    assign io_bus_sel    = r_sel;
    assign io_bus_we     = r_we;
    assign io_bus_addr   = {20'd0, r_addr};
    assign io_bus_dat2   = {16'd0, r_dat};
endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl with a 3-cycle-ack VGA text-memory model.
module tb_vga_console_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic [7:0]  color = 8'h00;
    logic        char_ready, busy, bus_sel, bus_we;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [31:0] bus_addr, bus_dat2, bus_dat4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vga_console_ctrl #(.COLS(80), .ROWS(30)) dut (
        .clk(clk), .reset(reset),
        .io_char_valid(char_valid), .io_char_ready(char_ready),
        .io_char_data(char_data), .io_color(color),
        .io_cursor_x(cursor_x), .io_cursor_y(cursor_y), .io_busy(busy),
        .io_bus_addr(bus_addr), .io_bus_dat2(bus_dat2), .io_bus_dat4(bus_dat4),
        .io_bus_sel(bus_sel), .io_bus_we(bus_we), .io_bus_ack(dev_ack)
    );

    // VGA device model: ack in the third sel cycle, upper read bits are junk
    logic [15:0] vmem [0:2399];
    logic [1:0]  dev_cnt = 2'd0;
    logic        dev_ack = 1'b0;
    logic        pat_req = 1'b0;

    function automatic logic [15:0] pat(input int a);
        return 16'(a * 37 + 256);
    endfunction

    assign bus_dat4 = (bus_addr[11:0] < 12'd2400) ? {16'hDEAD, vmem[bus_addr[11:0]]} : 32'hDEAD0000;

    always @(posedge clk) begin
        if (pat_req) begin
            for (int a = 0; a < 2400; a++) vmem[a] <= pat(a);
        end else if (bus_sel && dev_ack && bus_we && bus_addr[11:0] < 12'd2400) begin
            vmem[bus_addr[11:0]] <= bus_dat2[15:0];
        end
        if (!bus_sel) begin
            dev_cnt <= 2'd0;
            dev_ack <= 1'b0;
        end else begin
            dev_cnt <= dev_cnt + 2'd1;
            dev_ack <= (dev_cnt == 2'd1);
        end
    end

    // Bus monitor: transaction log plus protocol violation counter
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
    txn_t        q[$];
    int          viol = 0;
    int          sel_cycles = 0;
    logic        m_prev_sel = 1'b0, m_prev_done = 1'b0, m_prev_we = 1'b0;
    logic [31:0] m_prev_addr = '0, m_prev_dat = '0;
    logic        w_bad;

    assign w_bad = (bus_sel && (bus_addr[31:12] != 20'd0 || bus_dat2[31:16] != 16'd0))
                || (m_prev_done && bus_sel)
                || (m_prev_sel && !m_prev_done && bus_sel &&
                    (bus_addr != m_prev_addr || bus_we != m_prev_we || bus_dat2 != m_prev_dat));

    always @(posedge clk) begin
        if (bus_sel && dev_ack) q.push_back({bus_we, bus_addr, bus_we ? bus_dat2 : bus_dat4});
        viol        <= viol + (w_bad ? 1 : 0);
        sel_cycles  <= sel_cycles + (bus_sel ? 1 : 0);
        m_prev_sel  <= bus_sel;
        m_prev_done <= bus_sel && dev_ack;
        m_prev_we   <= bus_we;
        m_prev_addr <= bus_addr;
        m_prev_dat  <= bus_dat2;
    end

    task automatic send(input logic [7:0] c, input logic [7:0] col);
        int n;
        n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40000) begin
            n_checks++;
            $display("FAIL send_timeout ready=%b required 1", char_ready);
        end
        char_valid = 1'b1;
        char_data  = c;
        color      = col;
        @(posedge clk);
        #1 char_valid = 1'b0;
        $display("txn char=%02h color=%02h", c, col);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            $display("FAIL ready_timeout ready=%b required 1", char_ready);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #11;
        n_checks++; if (char_ready !== 1'b0) $display("FAIL rst_ready got=%b want=0", char_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (bus_sel !== 1'b0) $display("FAIL rst_sel got=%b want=0", bus_sel); else n_pass++;
        n_checks++; if (bus_we !== 1'b0) $display("FAIL rst_we got=%b want=0", bus_we); else n_pass++;
        n_checks++; if (bus_addr !== 32'd0) $display("FAIL rst_addr got=%h want=0", bus_addr); else n_pass++;
        n_checks++; if (bus_dat2 !== 32'd0) $display("FAIL rst_dat2 got=%h want=0", bus_dat2); else n_pass++;
        n_checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0)
            $display("FAIL rst_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y); else n_pass++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (char_ready !== 1'b1) $display("FAIL rst_release_ready got=%b want=1", char_ready); else n_pass++;
    endtask

    task automatic test_put();
        logic [3:0] s, r;
        logic [6:0] cx_mid;
        int base;
        base = q.size();
        s = '0; r = '0; cx_mid = '1;
        @(negedge clk);
        char_valid = 1'b1; char_data = 8'h41; color = 8'h07;
        @(posedge clk);
        #1 char_valid = 1'b0;
        $display("txn char=41 color=07");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s[i] = bus_sel;
            r[i] = char_ready;
            if (i == 1) cx_mid = cursor_x;
        end
        n_checks++; if (s !== 4'b0111) $display("FAIL put_sel_timing got=%b want=0111", s); else n_pass++;
        n_checks++; if (r !== 4'b1000) $display("FAIL put_ready_timing got=%b want=1000", r); else n_pass++;
        n_checks++; if (cx_mid !== 7'd0) $display("FAIL put_cursor_early got=%0d want=0", cx_mid); else n_pass++;
        n_checks++; if (q.size() - base != 1) $display("FAIL put_count got=%0d want=1", q.size() - base); else n_pass++;
        n_checks++; if (q[base].addr !== 32'd0) $display("FAIL put_addr got=%h want=0", q[base].addr); else n_pass++;
        n_checks++; if (q[base].we !== 1'b1) $display("FAIL put_we got=%b want=1", q[base].we); else n_pass++;
        n_checks++; if (q[base].data !== 32'h00000741) $display("FAIL put_dat2 got=%h want=00000741", q[base].data); else n_pass++;
        n_checks++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0)
            $display("FAIL put_cursor got=(%0d,%0d) want=(1,0)", cursor_x, cursor_y); else n_pass++;
    endtask

    task automatic test_line_wrap();
        int base, errs;
        send(8'h0D, 8'h07);
        wait_ready(10);
        n_checks++; if (cursor_x !== 7'd0) $display("FAIL wrap_cr_x got=%0d want=0", cursor_x); else n_pass++;
        base = q.size();
        for (int i = 0; i < 80; i++) send(8'h61 + 8'(i % 26), 8'h02);
        wait_ready(20);
        errs = 0;
        for (int i = 0; i < 80; i++)
            if (q[base + i].addr !== 32'(i) || q[base + i].we !== 1'b1) errs++;
        n_checks++; if (q.size() - base != 80) $display("FAIL wrap_count got=%0d want=80", q.size() - base); else n_pass++;
        n_checks++; if (errs != 0) $display("FAIL wrap_addr_seq bad=%0d want=0", errs); else n_pass++;
        n_checks++; if (q[base + 79].addr !== 32'd79 || q[base + 79].data !== 32'h00000262)
            $display("FAIL wrap_last got=%h:%h want=4f:00000262", q[base + 79].addr, q[base + 79].data); else n_pass++;
        n_checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd1)
            $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,1)", cursor_x, cursor_y); else n_pass++;
    endtask

    task automatic test_cr_bs();
        int sc0, base;
        send(8'h0A, 8'h07);
        send(8'h0A, 8'h07);
        for (int i = 0; i < 5; i++) send(8'h78, 8'h07);
        wait_ready(20);
        n_checks++; if (cursor_x !== 7'd5 || cursor_y !== 5'd3)
            $display("FAIL crbs_setup got=(%0d,%0d) want=(5,3)", cursor_x, cursor_y); else n_pass++;
        sc0 = sel_cycles;
        send(8'h0D, 8'h07);
        @(negedge clk);
        n_checks++; if (cursor_x !== 7'd0) $display("FAIL crbs_cr_x got=%0d want=0", cursor_x); else n_pass++;
        send(8'h08, 8'h07);
        wait_ready(10);
        n_checks++; if (sel_cycles != sc0) $display("FAIL crbs_no_bus got=%0d want=%0d", sel_cycles, sc0); else n_pass++;
        n_checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd3)
            $display("FAIL crbs_cursor got=(%0d,%0d) want=(0,3)", cursor_x, cursor_y); else n_pass++;
        base = q.size();
        send(8'h5A, 8'h03);
        send(8'h08, 8'h03);
        wait_ready(10);
        n_checks++; if (q.size() - base != 1 || q[base].addr !== 32'd240 || q[base].data !== 32'h0000035A)
            $display("FAIL crbs_put240 got=%0d:%h:%h want=1:f0:0000035a", q.size() - base, q[base].addr, q[base].data); else n_pass++;
        n_checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd3)
            $display("FAIL crbs_bs_cursor got=(%0d,%0d) want=(0,3)", cursor_x, cursor_y); else n_pass++;
    endtask

    task automatic test_scroll();
        int base, n, busy_low, early, oerr, merr, v0;
        for (int i = 0; i < 26; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 7; i++) send(8'h6B, 8'h07);
        wait_ready(20);
        n_checks++; if (cursor_x !== 7'd7 || cursor_y !== 5'd29)
            $display("FAIL scr_setup got=(%0d,%0d) want=(7,29)", cursor_x, cursor_y); else n_pass++;
        @(negedge clk) pat_req = 1'b1;
        @(negedge clk) pat_req = 1'b0;
        v0 = viol;
        base = q.size();
        send(8'h0A, 8'h07);
        n = 0; busy_low = 0; early = 0;
        while (n < 30000) begin
            @(negedge clk);
            if (char_ready === 1'b1) break;
            if (busy !== 1'b1) busy_low++;
            if (cursor_x !== 7'd7 || cursor_y !== 5'd29) early++;
            n++;
        end
        n_checks++; if (n >= 30000) $display("FAIL scr_timeout cycles=%0d limit=30000", n); else n_pass++;
        oerr = 0;
        if (q.size() - base == 4720) begin
            for (int k = 0; k < 2320; k++) begin
                if (q[base + 2*k] !== {1'b0, 32'(k + 80), {16'hDEAD, pat(k + 80)}}) oerr++;
                if (q[base + 2*k + 1] !== {1'b1, 32'(k), {16'h0000, pat(k + 80)}}) oerr++;
            end
            for (int j = 0; j < 80; j++)
                if (q[base + 4640 + j] !== {1'b1, 32'(2320 + j), 32'h00000720}) oerr++;
        end else oerr = -1;
        merr = 0;
        for (int a = 0; a < 2400; a++)
            if (vmem[a] !== ((a < 2320) ? pat(a + 80) : 16'h0720)) merr++;
        n_checks++; if (busy_low != 0) $display("FAIL scr_busy low_cycles=%0d want=0", busy_low); else n_pass++;
        n_checks++; if (early != 0) $display("FAIL scr_cursor_early cycles=%0d want=0", early); else n_pass++;
        n_checks++; if (q.size() - base != 4720) $display("FAIL scr_count got=%0d want=4720", q.size() - base); else n_pass++;
        n_checks++; if (oerr != 0) $display("FAIL scr_order bad=%0d want=0", oerr); else n_pass++;
        n_checks++; if (merr != 0) $display("FAIL scr_mem bad=%0d want=0", merr); else n_pass++;
        n_checks++; if (viol != v0) $display("FAIL scr_protocol violations=%0d want=0", viol - v0); else n_pass++;
        n_checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd29)
            $display("FAIL scr_cursor got=(%0d,%0d) want=(0,29)", cursor_x, cursor_y); else n_pass++;
    endtask

    task automatic test_clear();
        int base, errs, merr;
        base = q.size();
        send(8'h0C, 8'h1F);
        wait_ready(12000);
        errs = 0;
        if (q.size() - base == 2400) begin
            for (int k = 0; k < 2400; k++)
                if (q[base + k] !== {1'b1, 32'(k), 32'h00001F20}) errs++;
        end else errs = -1;
        merr = 0;
        for (int a = 0; a < 2400; a++) if (vmem[a] !== 16'h1F20) merr++;
        n_checks++; if (q.size() - base != 2400) $display("FAIL clr_count got=%0d want=2400", q.size() - base); else n_pass++;
        n_checks++; if (errs != 0) $display("FAIL clr_seq bad=%0d want=0", errs); else n_pass++;
        n_checks++; if (merr != 0) $display("FAIL clr_mem bad=%0d want=0", merr); else n_pass++;
        n_checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0)
            $display("FAIL clr_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y); else n_pass++;
    endtask

    task automatic test_reset_scroll();
        int n, base;
        for (int i = 0; i < 29; i++) send(8'h0A, 8'h07);
        send(8'h0A, 8'h07);
        repeat (40) @(negedge clk);
        n = 0;
        while (bus_sel !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (bus_sel !== 1'b1) $display("FAIL rsc_sel_before got=%b want=1", bus_sel); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus_sel !== 1'b0) $display("FAIL rsc_sel_drop got=%b want=0", bus_sel); else n_pass++;
        n_checks++; if (busy !== 1'b0 || char_ready !== 1'b0)
            $display("FAIL rsc_in_reset busy=%b ready=%b want=0,0", busy, char_ready); else n_pass++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (char_ready !== 1'b1) $display("FAIL rsc_ready got=%b want=1", char_ready); else n_pass++;
        n_checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0)
            $display("FAIL rsc_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y); else n_pass++;
        base = q.size();
        send(8'h42, 8'h07);
        wait_ready(20);
        n_checks++; if (q.size() - base != 1 || q[base].addr !== 32'd0 || q[base].data !== 32'h00000742)
            $display("FAIL rsc_put got=%0d:%h:%h want=1:0:00000742", q.size() - base, q[base].addr, q[base].data); else n_pass++;
        n_checks++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0)
            $display("FAIL rsc_put_cursor got=(%0d,%0d) want=(1,0)", cursor_x, cursor_y); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_put();
        test_line_wrap();
        test_cr_bs();
        test_scroll();
        test_clear();
        test_reset_scroll();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
